// File: rtl/sprite_draw_engine.sv
// ============================================================================
// Module   : sprite_draw_engine
// Purpose  : Writer side of the CHIP-8 VRAM. Executes DRW (XOR sprite draw
//            with collision detection) and CLS for the CPU core. Sprite rows
//            are fetched from main RAM; 1bpp VRAM is read-modify-written
//            through this block's own port (the video scanner uses the other).
//            VRAM byte address = {8'b0, y[4:0], x[5:3]}, pixel x at bit x[2:0]
//            (bit 0 = leftmost pixel of the byte).
// Ports    : clk_in, rst_in (async, active-low)
//            draw_start_in / cls_start_in : 1-cycle start pulses
//            x_in, y_in, n_in, i_addr_in  : DRW operands (sampled at start)
//            mem_addr_out / mem_data_in   : main-RAM read port
//            vram_addr_out, vram_data_in, vram_data_out, vram_we_out : VRAM port
//            busy_out, done_out, collision_out : status to the CPU core
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sprite_draw_engine #(
  parameter int MEM_LATENCY  = 2,
  parameter int VRAM_LATENCY = 2,
  parameter int CLIP_EDGES   = 1
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        draw_start_in,
  input  logic        cls_start_in,
  input  logic [7:0]  x_in,
  input  logic [7:0]  y_in,
  input  logic [3:0]  n_in,
  input  logic [11:0] i_addr_in,
  output logic [11:0] mem_addr_out,
  input  logic [7:0]  mem_data_in,
  output logic [15:0] vram_addr_out,
  input  logic [7:0]  vram_data_in,
  output logic [7:0]  vram_data_out,
  output logic        vram_we_out,
  output logic        busy_out,
  output logic        done_out,
  output logic        collision_out
);

  localparam logic [3:0] IDLE  = 4'd0;
  localparam logic [3:0] FETCH = 4'd1;
  localparam logic [3:0] RD_L  = 4'd2;
  localparam logic [3:0] WR_L  = 4'd3;
  localparam logic [3:0] RD_R  = 4'd4;
  localparam logic [3:0] WR_R  = 4'd5;
  localparam logic [3:0] NEXT  = 4'd6;
  localparam logic [3:0] CLEAR = 4'd7;
  localparam logic [3:0] DONE  = 4'd8;

  // Last cycle of each hold window: address held LATENCY+1 cycles.
  localparam logic [7:0] MEM_LAST  = 8'(MEM_LATENCY);
  localparam logic [7:0] VRAM_LAST = 8'(VRAM_LATENCY);
  localparam logic       CLIP      = (CLIP_EDGES != 0);

  logic [3:0]  state;
  logic [7:0]  cnt;        // latency counter, doubles as CLS address
  logic [2:0]  xo;         // pixel offset within the first byte
  logic [2:0]  xb;         // first column byte
  logic [4:0]  yr;         // start row
  logic [3:0]  row;        // current sprite row
  logic [3:0]  n_rows;
  logic [11:0] i_base;
  logic [15:0] pat;        // shifted row pattern, [7:0] left byte, [15:8] right
  logic [7:0]  old;        // VRAM byte captured by the read phase
  logic        collision;

  // x_in[7:6] and y_in[7:5] are ignored: coordinates wrap on screen size.
  logic unused_bits;
  assign unused_bits = ^{x_in[7:6], y_in[7:5]};

  logic [7:0]  sprite_rev;
  logic [15:0] row_pat;
  logic [4:0]  y_tgt;
  logic [2:0]  xb_right;
  logic [4:0]  row_nxt;
  logic [5:0]  y_nxt;
  logic        last_row;
  logic        skip_right;

  always_comb begin
    // Sprite MSB is the leftmost pixel but VRAM bit 0 is leftmost.
    sprite_rev = '0;
    for (int b = 0; b < 8; b++) begin
      sprite_rev[b] = mem_data_in[7-b];
    end
    row_pat    = {8'b0, sprite_rev} << xo;
    y_tgt      = yr + {1'b0, row};
    xb_right   = xb + 3'd1;             // wraps 7 -> 0 for the non-clipping case
    row_nxt    = {1'b0, row} + 5'd1;
    y_nxt      = {1'b0, yr} + {1'b0, row_nxt};
    // ">=" lets n==0 finish straight from NEXT without any fetch.
    last_row   = (row_nxt >= {1'b0, n_rows}) || (CLIP && (y_nxt > 6'd31));
    skip_right = (xo == 3'd0) || (CLIP && (xb == 3'd7));
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state     <= IDLE;
      cnt       <= '0;
      xo        <= '0;
      xb        <= '0;
      yr        <= '0;
      row       <= '0;
      n_rows    <= '0;
      i_base    <= '0;
      pat       <= '0;
      old       <= '0;
      collision <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (cls_start_in) begin
            collision <= 1'b0;
            state     <= CLEAR;
          end else if (draw_start_in) begin
            xo        <= x_in[2:0];
            xb        <= x_in[5:3];
            yr        <= y_in[4:0];
            row       <= '0;
            n_rows    <= n_in;
            i_base    <= i_addr_in;
            collision <= 1'b0;
            state     <= (n_in == 4'd0) ? NEXT : FETCH;
          end
        end
        FETCH: begin
          if (cnt == MEM_LAST) begin
            pat   <= row_pat;
            cnt   <= '0;
            state <= RD_L;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        RD_L: begin
          if (cnt == VRAM_LAST) begin
            old   <= vram_data_in;
            cnt   <= '0;
            state <= WR_L;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        WR_L: begin
          collision <= collision | (|(old & pat[7:0]));
          state     <= skip_right ? NEXT : RD_R;
        end
        RD_R: begin
          if (cnt == VRAM_LAST) begin
            old   <= vram_data_in;
            cnt   <= '0;
            state <= WR_R;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        WR_R: begin
          collision <= collision | (|(old & pat[15:8]));
          state     <= NEXT;
        end
        NEXT: begin
          cnt <= '0;
          if (last_row) begin
            state <= DONE;
          end else begin
            row   <= row_nxt[3:0];
            state <= FETCH;
          end
        end
        CLEAR: begin
          if (cnt == 8'hFF) begin
            state <= DONE;
          end
          cnt <= cnt + 8'd1;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Outputs decode from state so an asynchronous reset clears them at once.
  always_comb begin
    mem_addr_out  = '0;
    vram_addr_out = '0;
    vram_data_out = '0;
    vram_we_out   = 1'b0;
    case (state)
      FETCH: mem_addr_out = i_base + {8'b0, row};
      RD_L:  vram_addr_out = {8'b0, y_tgt, xb};
      WR_L: begin
        vram_addr_out = {8'b0, y_tgt, xb};
        vram_data_out = old ^ pat[7:0];
        vram_we_out   = 1'b1;
      end
      RD_R:  vram_addr_out = {8'b0, y_tgt, xb_right};
      WR_R: begin
        vram_addr_out = {8'b0, y_tgt, xb_right};
        vram_data_out = old ^ pat[15:8];
        vram_we_out   = 1'b1;
      end
      CLEAR: begin
        vram_addr_out = {8'b0, cnt};
        vram_we_out   = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy_out      = (state != IDLE);
  assign done_out      = (state == DONE);
  assign collision_out = collision;

endmodule

`default_nettype wire

// File: tb/tb_sprite_draw_engine.sv
// ============================================================================
// Module   : tb_sprite_draw_engine
// Purpose  : Self-checking bench for sprite_draw_engine. Provides latency
//            models of main RAM and VRAM, a pixel-level reference of DRW/CLS
//            that predicts the VRAM write sequence, collision flag and
//            completion latency, and directed plus randomized operations.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sprite_draw_engine;

  localparam int ML   = 2;
  localparam int VL   = 2;
  localparam int CLIP = 1;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        draw_start_in, cls_start_in;
  logic [7:0]  x_in, y_in;
  logic [3:0]  n_in;
  logic [11:0] i_addr_in;
  logic [11:0] mem_addr_out;
  logic [7:0]  mem_data_in;
  logic [15:0] vram_addr_out;
  logic [7:0]  vram_data_in, vram_data_out;
  logic        vram_we_out, busy_out, done_out, collision_out;

  sprite_draw_engine #(
    .MEM_LATENCY (ML),
    .VRAM_LATENCY(VL),
    .CLIP_EDGES  (CLIP)
  ) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .draw_start_in (draw_start_in),
    .cls_start_in  (cls_start_in),
    .x_in          (x_in),
    .y_in          (y_in),
    .n_in          (n_in),
    .i_addr_in     (i_addr_in),
    .mem_addr_out  (mem_addr_out),
    .mem_data_in   (mem_data_in),
    .vram_addr_out (vram_addr_out),
    .vram_data_in  (vram_data_in),
    .vram_data_out (vram_data_out),
    .vram_we_out   (vram_we_out),
    .busy_out      (busy_out),
    .done_out      (done_out),
    .collision_out (collision_out)
  );

  always #5 clk_in = ~clk_in;

  // ---------------- memory models ----------------
  logic [7:0]  ram      [4096];
  logic [7:0]  vram     [256];
  logic [7:0]  ref_vram [256];
  logic [7:0]  mpipe    [ML];
  logic [7:0]  vpipe    [VL];
  logic [23:0] wlog  [$];
  logic [23:0] exp_q [$];
  int          done_cnt  = 0;
  int          probe_cnt = 0;
  int          checks = 0;
  int          errors = 0;

  assign mem_data_in  = mpipe[ML-1];
  assign vram_data_in = vpipe[VL-1];

  always @(posedge clk_in) begin
    mpipe[0] <= ram[mem_addr_out];
    for (int i = 1; i < ML; i++) mpipe[i] <= mpipe[i-1];
    vpipe[0] <= vram[vram_addr_out[7:0]];
    for (int i = 1; i < VL; i++) vpipe[i] <= vpipe[i-1];
    if (vram_we_out) begin
      wlog.push_back({vram_addr_out, vram_data_out});
      vram[vram_addr_out[7:0]] <= vram_data_out;
    end
    if (done_out) done_cnt++;
    if (mem_addr_out == 12'h121) probe_cnt++;
  end

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Pixel-by-pixel view of DRW: each lit sprite pixel lands on column x0+k,
  // clipped or wrapped at the screen edge, grouped into the bytes touched.
  task automatic model_draw(input logic [7:0] x, input logic [7:0] y, input logic [3:0] n,
                            input logic [11:0] ia, output int cyc, output logic coll);
    int x0, y0, ty, col, xbyte, rbyte, a;
    bit has_r;
    logic [7:0] spr, lb, rb, o;
    exp_q.delete();
    x0 = int'(x) % 64;
    y0 = int'(y) % 32;
    xbyte = x0 / 8;
    rbyte = (xbyte + 1) % 8;
    has_r = (x0 % 8 != 0) && !(CLIP != 0 && xbyte == 7);
    coll = 1'b0;
    cyc = (n == 0) ? 1 : 0;
    for (int r = 0; r < int'(n); r++) begin
      ty = y0 + r;
      if (ty > 31) begin
        if (CLIP != 0) break;
        ty = ty - 32;
      end
      spr = ram[(int'(ia) + r) % 4096];
      lb = '0;
      rb = '0;
      for (int k = 0; k < 8; k++) begin
        if (spr[7-k]) begin
          col = x0 + k;
          if (col > 63) begin
            if (CLIP != 0) continue;
            col = col - 64;
          end
          if (col / 8 == xbyte) lb[col%8] = 1'b1;
          else                  rb[col%8] = 1'b1;
        end
      end
      a = ty * 8 + xbyte;
      o = ref_vram[a];
      coll = coll | (|(o & lb));
      ref_vram[a] = o ^ lb;
      exp_q.push_back({a[15:0], o ^ lb});
      if (has_r) begin
        a = ty * 8 + rbyte;
        o = ref_vram[a];
        coll = coll | (|(o & rb));
        ref_vram[a] = o ^ rb;
        exp_q.push_back({a[15:0], o ^ rb});
      end
      cyc += (ML + 1) + (VL + 2) * (has_r ? 2 : 1) + 1;
    end
  endtask

  task automatic model_cls();
    exp_q.delete();
    for (int a = 0; a < 256; a++) begin
      exp_q.push_back({a[15:0], 8'h00});
      ref_vram[a] = 8'h00;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic run_op(input logic drw, input logic cls, input logic [7:0] x, input logic [7:0] y,
                        input logic [3:0] n, input logic [11:0] ia, input bit poke, output int cyc);
    wlog.delete();
    @(negedge clk_in);
    draw_start_in = drw;
    cls_start_in  = cls;
    x_in = x; y_in = y; n_in = n; i_addr_in = ia;
    @(posedge clk_in);
    #1;
    draw_start_in = 1'b0;
    cls_start_in  = 1'b0;
    check_value("busy_after_start", busy_out, 1);
    cyc = -1;
    for (int k = 1; k <= 400; k++) begin
      @(posedge clk_in);
      #1;
      cls_start_in = poke && (k == 2);
      if (done_out) begin
        cyc = k;
        break;
      end
    end
    cls_start_in = 1'b0;
    if (cyc < 0) check_value("done_timeout", 0, 1);
    @(posedge clk_in);
    #1;
    check_value("idle_after_done", {busy_out, done_out}, 0);
  endtask

  task automatic compare_writes(input string tag);
    int m;
    check_value({tag, "_nwrites"}, wlog.size(), exp_q.size());
    m = (wlog.size() < exp_q.size()) ? wlog.size() : exp_q.size();
    for (int i = 0; i < m; i++)
      check_value($sformatf("%s_w%0d", tag, i), wlog[i], exp_q[i]);
  endtask

  task automatic drw(input string tag, input logic [7:0] x, input logic [7:0] y,
                     input logic [3:0] n, input logic [11:0] ia, input bit poke);
    int cyc_e, cyc;
    logic coll_e;
    model_draw(x, y, n, ia, cyc_e, coll_e);
    run_op(1'b1, 1'b0, x, y, n, ia, poke, cyc);
    check_value({tag, "_latency"}, cyc, cyc_e);
    check_value({tag, "_collision"}, collision_out, coll_e);
    compare_writes(tag);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, d0, mism;
    rst_in = 1'b0;
    draw_start_in = 1'b0;
    cls_start_in  = 1'b0;
    x_in = '0; y_in = '0; n_in = '0; i_addr_in = '0;
    for (int i = 0; i < 4096; i++) ram[i] = 8'($urandom);
    for (int i = 0; i < 256; i++) begin
      vram[i] = 8'h00;
      ref_vram[i] = 8'h00;
    end
    ram[12'h100] = 8'hF0;
    ram[12'h110] = 8'hFF;
    ram[12'h120] = 8'hFF;
    ram[12'h121] = 8'hFF;

    repeat (3) @(posedge clk_in);
    #1;
    check_value("reset_outputs",
                {vram_we_out, busy_out, done_out, collision_out, vram_addr_out, mem_addr_out, vram_data_out}, 0);
    @(negedge clk_in);
    rst_in = 1'b1;

    // Single-byte draw, then the same draw again erases it and collides.
    drw("t1", 8'd0, 8'd0, 4'd1, 12'h100, 1'b0);
    drw("t2", 8'd0, 8'd0, 4'd1, 12'h100, 1'b0);
    // Straddling two bytes; a CLS pulse while busy must be ignored.
    drw("t3", 8'h45, 8'd2, 4'd1, 12'h110, 1'b1);
    // Right and bottom clipping: second row must never be fetched.
    probe_cnt = 0;
    drw("t4", 8'd60, 8'd31, 4'd2, 12'h120, 1'b0);
    check_value("t4_row1_fetches", probe_cnt, 0);

    // CLS, then CLS and DRW together: CLS wins.
    model_cls();
    run_op(1'b0, 1'b1, 8'd0, 8'd0, 4'd1, 12'h100, 1'b0, cyc);
    compare_writes("t5a");
    model_cls();
    d0 = done_cnt;
    run_op(1'b1, 1'b1, 8'd0, 8'd0, 4'd1, 12'h100, 1'b0, cyc);
    repeat (6) @(posedge clk_in);
    #1;
    compare_writes("t5b");
    check_value("t5_done_pulses", done_cnt - d0, 1);
    check_value("t5_collision", collision_out, 0);
    check_value("t5_busy_after", busy_out, 0);

    // Reset during the right-byte write of a straddling draw.
    d0 = done_cnt;
    @(negedge clk_in);
    draw_start_in = 1'b1;
    x_in = 8'h45; y_in = 8'd2; n_in = 4'd1; i_addr_in = 12'h110;
    @(posedge clk_in);
    #1;
    draw_start_in = 1'b0;
    repeat (10) @(posedge clk_in);
    #1;
    check_value("t6_in_wr_r", {vram_we_out, vram_addr_out}, {1'b1, 16'd17});
    rst_in = 1'b0;
    #1;
    check_value("t6_reset_outputs",
                {vram_we_out, busy_out, done_out, collision_out, vram_addr_out, mem_addr_out, vram_data_out}, 0);
    ref_vram[16] = ref_vram[16] ^ 8'hE0;  // left byte was already written
    @(negedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b1;
    check_value("t6_no_done", done_cnt - d0, 0);
    drw("t6_after", 8'd0, 8'd0, 4'd1, 12'h100, 1'b0);

    // Randomized draws, including n=0 and I wrapping past 0xFFF.
    for (int t = 0; t < 24; t++) begin
      logic [11:0] ia;
      ia = ($urandom_range(0, 3) == 0) ? 12'(12'hFF8 + $urandom_range(0, 7)) : 12'($urandom);
      drw($sformatf("rnd%0d", t), 8'($urandom), 8'($urandom), 4'($urandom_range(0, 15)), ia, 1'b0);
    end

    mism = 0;
    for (int a = 0; a < 256; a++)
      if (vram[a] !== ref_vram[a]) mism++;
    check_value("vram_final_mismatches", mism, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
